// File: rtl/stoch_to_bin.sv
// stoch_to_bin: converts a unipolar stochastic bitstream to binary by counting
// ones over back-to-back windows of 2^WIDTH valid samples.
// Latency: result/result_valid appear one cycle after the final window sample.
// Backpressure: none; in_valid=0 simply stalls the window for any number of cycles.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   run           level; high keeps windows running, low stops after current window
//   in_valid      bit_in carries a sample this cycle
//   bit_in        stochastic stream bit
//   busy          high while a window is in progress
//   sample_idx    index of the next sample within the current window
//   result        ones count of the last completed window (0..2^WIDTH)
//   result_valid  one-cycle pulse when result updates
//   win_count     completed windows since reset, modulo 256
module stoch_to_bin #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             in_valid,
  input  logic             bit_in,
  output logic             busy,
  output logic [WIDTH-1:0] sample_idx,
  output logic [WIDTH:0]   result,
  output logic             result_valid,
  output logic [7:0]       win_count
);

  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic [WIDTH-1:0] LAST_IDX = {WIDTH{1'b1}};

  state_t           state, state_nxt;
  logic [WIDTH:0]   acc, acc_nxt;
  logic [WIDTH-1:0] idx_nxt;
  logic [WIDTH:0]   result_nxt;
  logic             result_valid_nxt;
  logic [7:0]       win_count_nxt;
  logic [WIDTH:0]   bit_ext;

  assign bit_ext = {{WIDTH{1'b0}}, bit_in};
  assign busy    = (state == ACCUM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      acc          <= '0;
      sample_idx   <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      win_count    <= '0;
    end else begin
      state        <= state_nxt;
      acc          <= acc_nxt;
      sample_idx   <= idx_nxt;
      result       <= result_nxt;
      result_valid <= result_valid_nxt;
      win_count    <= win_count_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    acc_nxt          = acc;
    idx_nxt          = sample_idx;
    result_nxt       = result;
    result_valid_nxt = 1'b0;
    win_count_nxt    = win_count;

    case (state)
      IDLE: begin
        acc_nxt = '0;
        idx_nxt = '0;
        // The run=1 entry cycle is already sample slot 0 of the window.
        if (run) begin
          state_nxt = ACCUM;
          if (in_valid) begin
            acc_nxt = bit_ext;
            idx_nxt = {{(WIDTH-1){1'b0}}, 1'b1};
          end
        end
      end

      ACCUM: begin
        if (in_valid) begin
          if (sample_idx == LAST_IDX) begin
            // Final sample: publish and restart with no gap cycle if run held.
            result_nxt       = acc + bit_ext;
            result_valid_nxt = 1'b1;
            win_count_nxt    = win_count + 8'd1;
            acc_nxt          = '0;
            idx_nxt          = '0;
            state_nxt        = run ? ACCUM : IDLE;
          end else begin
            acc_nxt = acc + bit_ext;
            idx_nxt = sample_idx + 1'b1;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_stoch_to_bin.sv
// Self-checking bench for stoch_to_bin: a queue-based window model checked
// every cycle, plus directed windows with hand-computed literal results.
module tb_stoch_to_bin;
  localparam int WIDTH = 5;
  localparam int N     = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             run = 1'b0;
  logic             in_valid = 1'b0;
  logic             bit_in = 1'b0;
  logic             busy;
  logic [WIDTH-1:0] sample_idx;
  logic [WIDTH:0]   result;
  logic             result_valid;
  logic [7:0]       win_count;

  stoch_to_bin #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .run(run), .in_valid(in_valid), .bit_in(bit_in),
    .busy(busy), .sample_idx(sample_idx), .result(result),
    .result_valid(result_valid), .win_count(win_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // Model: a window is a list of accepted samples; it completes when full.
  bit m_win = 0;
  bit m_q[$];
  int m_result = 0;
  bit m_rv = 0;
  int m_wc = 0;

  function automatic int sum_q();
    int s = 0;
    foreach (m_q[i]) s += int'(m_q[i]);
    return s;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_win = 0; m_q.delete(); m_result = 0; m_rv = 0; m_wc = 0;
    end else begin
      m_rv = 0;
      if (!m_win) begin
        if (run) begin
          m_win = 1;
          if (in_valid) m_q.push_back(bit_in);
        end
      end else if (in_valid) begin
        m_q.push_back(bit_in);
        if (m_q.size() == N) begin
          m_result = sum_q();
          m_rv = 1;
          m_wc = (m_wc + 1) % 256;
          m_q.delete();
          m_win = run;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", int'(busy), int'(m_win));
      chk("sample_idx", int'(sample_idx), m_q.size());
      chk("result", int'(result), m_result);
      chk("result_valid", int'(result_valid), int'(m_rv));
      chk("win_count", int'(win_count), m_wc);
    end
  end

  task automatic step(input logic r, input logic v, input logic b);
    run = r; in_valid = v; bit_in = b;
    @(negedge clk);
  endtask

  initial begin
    // Reset held 3 cycles with run/in_valid active.
    rst = 1'b1; run = 1'b1; in_valid = 1'b1; bit_in = 1'b1;
    @(negedge clk);
    chk_en = 1;
    @(negedge clk); @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_wc", int'(win_count), 0);
    chk("rst_idx", int'(sample_idx), 0);
    rst = 1'b0;
    repeat (4) step(0, 1, 1);
    chk("idle_busy", int'(busy), 0);

    // Single window: 12 ones, run pulsed for the entry cycle only.
    step(1, 1, 1);
    for (int i = 1; i < N; i++) begin
      step(0, 1, i < 12);
      if (i == 15) chk("mid_busy", int'(busy), 1);
    end
    chk("w1_rv", int'(result_valid), 1);
    chk("w1_result", int'(result), 12);
    chk("w1_wc", int'(win_count), 1);
    chk("w1_busy", int'(busy), 0);
    step(0, 0, 0);
    chk("w1_rv_drop", int'(result_valid), 0);
    chk("w1_hold", int'(result), 12);

    // Extremes: all ones then all zeros, back to back.
    for (int i = 0; i < N; i++) step(1, 1, 1);
    chk("ones_result", int'(result), 32);
    chk("ones_rv", int'(result_valid), 1);
    chk("ones_busy", int'(busy), 1);
    for (int i = 0; i < N; i++) begin
      step(i != N - 1, 1, 0);
      if (i == 0) chk("gapless_idx", int'(sample_idx), 1);
    end
    chk("zeros_result", int'(result), 0);
    chk("zeros_rv", int'(result_valid), 1);
    chk("zeros_wc", int'(win_count), 3);

    // Stalls with bit_in=1 on invalid cycles.
    for (int i = 0; i < N; i++) begin
      step(i == 0, 1, (i % 2) == 0);
      if (i < N - 1) begin
        repeat ($urandom_range(1, 3)) step(0, 0, 1);
        chk("stall_idx", int'(sample_idx), i + 1);
      end
    end
    chk("stall_result", int'(result), 16);
    chk("stall_wc", int'(win_count), 4);

    // Continuous run: 10 windows of 20/32, then through to 256 windows.
    rst = 1'b1; step(0, 0, 0); rst = 1'b0;
    for (int w = 0; w < 256; w++) begin
      for (int j = 0; j < N; j++)
        step(!(w == 255 && j == N - 1), 1,
             (w < 10) ? (j < 20) : logic'($urandom_range(0, 1)));
      if (w == 9) begin
        chk("cont_result", int'(result), 20);
        chk("cont_wc", int'(win_count), 10);
      end
    end
    chk("wrap_wc", int'(win_count), 0);
    chk("wrap_busy", int'(busy), 0);

    // Reset mid-window discards the partial count.
    for (int i = 0; i < 17; i++) step(i == 0, 1, i < 9);
    rst = 1'b1; step(0, 1, 1); rst = 1'b0;
    chk("mid_rst_result", int'(result), 0);
    chk("mid_rst_rv", int'(result_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    for (int i = 0; i < N; i++) step(i == 0, 1, i < 5);
    chk("fresh_result", int'(result), 5);
    chk("fresh_wc", int'(win_count), 1);

    // Randomized traffic with occasional resets; the model checks every cycle.
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           logic'($urandom_range(0, 1)));
    end
    rst = 1'b0;
    repeat (200) step(0, 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
